// File: rtl/stacker_pkg.sv
// rtl/stacker_pkg.sv - shared state encoding, direction and colour constants for the stacker
package stacker_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        IDLE_WAIT = 4'd1,
        PLOT      = 4'd2,
        HOLD      = 4'd3,
        ERASE     = 4'd4,
        MOVE      = 4'd5,
        LATCH     = 4'd6,
        WIN       = 4'd7,
        OVER      = 4'd8,
        CLEAR     = 4'd9
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int ERASE_COLOUR = 0;

endpackage

// File: rtl/stacker_seq_ctrl_if.sv
// rtl/stacker_seq_ctrl_if.sv - pixel write bus towards the VGA adapter
interface stacker_seq_ctrl_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                writeEn;

    modport master (output x, output y, output colour, output writeEn);
    modport slave  (input  x, input  y, input  colour, input  writeEn);
endinterface

// File: rtl/stacker_pix_walk.sv
// rtl/stacker_pix_walk.sv - raster counter over one block, shared by plot and erase
module stacker_pix_walk
    import stacker_pkg::*;
#(
    parameter int BLK_W = 4,
    parameter int BLK_H = 4,
    localparam int PX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1,
    localparam int PY_W = (BLK_H > 1) ? $clog2(BLK_H) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic            clr,
    output logic [PX_W-1:0] px_nxt,
    output logic [PY_W-1:0] py_nxt,
    output logic            last
);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(BLK_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(BLK_H - 1);

    logic [PX_W-1:0] px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;

    assign last   = (px_q == PX_LAST) && (py_q == PY_LAST);
    assign px_nxt = px_d;
    assign py_nxt = py_d;

    // advance in raster order; the last pixel wraps both counters back to the origin
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (clr) begin
            px_d = '0;
            py_d = '0;
        end else if (en) begin
            if (px_q == PX_LAST) begin
                px_d = '0;
                py_d = (py_q == PY_LAST) ? '0 : py_q + PY_W'(1);
            end else begin
                px_d = px_q + PX_W'(1);
            end
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

endmodule

// File: rtl/stacker_seq_ctrl.sv
// rtl/stacker_seq_ctrl.sv - plot/hold/erase/move stacking sequencer with row latching
module stacker_seq_ctrl
    import stacker_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int NUM_ROWS     = 8,
    parameter int BLK_W        = 4,
    parameter int BLK_H        = 4,
    parameter int DELAY_CYCLES = 12500000,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int COLOUR_W     = 3,
    parameter logic [COLOUR_W-1:0] BLK_COLOUR = COLOUR_W'(3'b111)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        stop,
    stacker_seq_ctrl_if.master          pix,
    output logic [$clog2(NUM_ROWS)-1:0] row_idx,
    output logic                        win,
    output logic                        game_over,
    output logic [3:0]                  state_dbg
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int PX_W  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int PY_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COL_W-1:0]  prev_col_q, prev_col_d;
    logic              dir_q, dir_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              stop_pend_q, stop_pend_d;
    logic              stop_q;
    logic              win_q, win_d;
    logic              game_over_q, game_over_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;

    logic              walk;
    logic              walk_last;
    logic              stop_edge;
    logic [PX_W-1:0]   px_nxt;
    logic [PY_W-1:0]   py_nxt;

    assign walk      = (state_q == PLOT) || (state_q == ERASE);
    assign stop_edge = stop & ~stop_q;

    stacker_pix_walk #(
        .BLK_W (BLK_W),
        .BLK_H (BLK_H)
    ) u_pix_walk (
        .clk    (clk),
        .resetn (resetn),
        .en     (walk),
        .clr    (~walk),
        .px_nxt (px_nxt),
        .py_nxt (py_nxt),
        .last   (walk_last)
    );

    assign pix.writeEn = walk;
    assign pix.colour  = (state_q == PLOT) ? BLK_COLOUR : COLOUR_W'(ERASE_COLOUR);
    assign pix.x       = x_q;
    assign pix.y       = y_q;
    assign row_idx     = row_q;
    assign win         = win_q;
    assign game_over   = game_over_q;
    assign state_dbg   = state_q;

    // next-state, board position and flag updates
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        prev_col_d  = prev_col_q;
        dir_d       = dir_q;
        row_d       = row_q;
        dly_d       = dly_q;
        stop_pend_d = stop_pend_q;
        win_d       = win_q;
        game_over_d = game_over_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = IDLE_WAIT;
            end
            IDLE_WAIT: begin
                if (!start) state_d = PLOT;
            end
            PLOT: begin
                if (stop_edge) stop_pend_d = 1'b1;
                if (walk_last) state_d = HOLD;
            end
            HOLD: begin
                if (stop_edge || stop_pend_q) begin
                    state_d     = LATCH;
                    stop_pend_d = 1'b0;
                    dly_d       = '0;
                end else if (dly_q == DLY_LAST) begin
                    state_d = ERASE;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ERASE: begin
                if (stop_edge) stop_pend_d = 1'b1;
                if (walk_last) state_d = MOVE;
            end
            MOVE: begin
                if (stop_edge) stop_pend_d = 1'b1;
                if (dir_q == DIR_RIGHT) begin
                    if (col_q == COL_LAST) begin
                        dir_d = DIR_LEFT;
                        col_d = COL_W'(COLS - 2);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    if (col_q == '0) begin
                        dir_d = DIR_RIGHT;
                        col_d = COL_W'(1);
                    end else begin
                        col_d = col_q - COL_W'(1);
                    end
                end
                state_d = PLOT;
            end
            LATCH: begin
                if ((row_q != '0) && (col_q != prev_col_q)) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                end else if (row_q == ROW_LAST) begin
                    state_d = WIN;
                    win_d   = 1'b1;
                end else begin
                    prev_col_d = col_q;
                    row_d      = row_q + ROW_W'(1);
                    col_d      = '0;
                    dir_d      = DIR_RIGHT;
                    dly_d      = '0;
                    state_d    = PLOT;
                end
            end
            WIN, OVER: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                row_d       = '0;
                col_d       = '0;
                dir_d       = DIR_RIGHT;
                prev_col_d  = '0;
                win_d       = 1'b0;
                game_over_d = 1'b0;
                dly_d       = '0;
                stop_pend_d = 1'b0;
                state_d     = IDLE_WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // pixel address follows the next position so it lines up with writeEn
    always_comb begin
        x_d = X_W'(32'(col_d) * 32'(BLK_W) + 32'(px_nxt));
        y_d = Y_W'((32'(NUM_ROWS - 1) - 32'(row_d)) * 32'(BLK_H) + 32'(py_nxt));
    end

    // state, position, flags and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            col_q       <= '0;
            prev_col_q  <= '0;
            dir_q       <= DIR_RIGHT;
            row_q       <= '0;
            dly_q       <= '0;
            stop_pend_q <= 1'b0;
            stop_q      <= 1'b0;
            win_q       <= 1'b0;
            game_over_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            prev_col_q  <= prev_col_d;
            dir_q       <= dir_d;
            row_q       <= row_d;
            dly_q       <= dly_d;
            stop_pend_q <= stop_pend_d;
            stop_q      <= stop;
            win_q       <= win_d;
            game_over_q <= game_over_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

endmodule

// File: tb/tb_stacker_seq_ctrl.sv
// tb/tb_stacker_seq_ctrl.sv - randomized stacking games checked against a write-stream model
module tb_stacker_seq_ctrl;
    localparam int COLS  = 4;
    localparam int NR    = 8;
    localparam int BW    = 4;
    localparam int BH    = 4;
    localparam int DLY   = 5;
    localparam int BLK_C = 7;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] row_idx;
    logic       win;
    logic       game_over;
    logic [3:0] state_dbg;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stop_left = 0;

    stacker_seq_ctrl_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) pix ();

    stacker_seq_ctrl #(
        .COLS(COLS), .NUM_ROWS(NR), .BLK_W(BW), .BLK_H(BH), .DELAY_CYCLES(DLY),
        .X_W(8), .Y_W(7), .COLOUR_W(3), .BLK_COLOUR(3'b111)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .pix(pix),
        .row_idx(row_idx), .win(win), .game_over(game_over), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // column reached after s moves of a bouncing block starting at 0 going right
    function automatic int tri_col(input int s);
        int per;
        int p;
        per = 2 * (COLS - 1);
        p = s % per;
        return (p < COLS) ? p : per - p;
    endfunction

    function automatic int pack(input int x, input int y, input int c);
        return (x << 16) | (y << 8) | c;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (stop_left > 0) begin
            stop_left--;
            if (stop_left == 0) stop = 1'b0;
        end
        if (cyc > 60000) begin
            check_eq("watchdog", cyc, 0);
            finish_now();
        end
    endtask

    task automatic press(input int len);
        stop = 1'b1;
        stop_left = len;
    endtask

    task automatic next_write(output int x, output int y, output int c, output int t);
        int n;
        n = 0;
        step();
        while (pix.writeEn !== 1'b1) begin
            n++;
            if (n > 200) begin
                check_eq("write_timeout", 0, 1);
                finish_now();
            end
            step();
        end
        x = int'(pix.x);
        y = int'(pix.y);
        c = int'(pix.colour);
        t = cyc;
    endtask

    // one 16-pixel walk; optionally presses stop right after write number trig_k
    task automatic burst(input string tag, input int col, input int row, input int c,
                         input int t_first, input int trig_k, input int plen,
                         output int t_last);
        int wx, wy, wc, wt, prev;
        prev = 0;
        for (int i = 0; i < BW * BH; i++) begin
            next_write(wx, wy, wc, wt);
            if (i == 0) begin
                if (t_first >= 0) check_eq({tag, "_start_time"}, wt, t_first);
                if (c == BLK_C) begin
                    check_eq("row_idx", int'(row_idx), row);
                    check_eq("flags_in_play", int'({win, game_over}), 0);
                end
            end else begin
                check_eq({tag, "_contig"}, wt, prev + 1);
            end
            check_eq({tag, "_pixel"}, pack(wx, wy, wc),
                     pack(col * BW + i % BW, (NR - 1 - row) * BH + i / BW, c));
            if (i + 1 == trig_k) press(plen);
            prev = wt;
        end
        t_last = prev;
    endtask

    // phase 0: press during plot, 1: during hold, 2: during erase/move (latched next step)
    task automatic play_row(input int r, input int s_lat, input int phase, input int k,
                            input int j, input int m, input int plen, input int t_first,
                            output int t_next);
        int trig, first, tp, te, col;
        trig = (phase == 2) ? s_lat - 1 : s_lat;
        first = t_first;
        t_next = -1;
        for (int st = 0; st < 32; st++) begin
            col = tri_col(st);
            burst("plot", col, r, BLK_C, first, (st == trig && phase == 0) ? k : 0, plen, tp);
            if (st == s_lat) begin
                if (phase == 1) begin
                    repeat (j) step();
                    press(plen);
                    t_next = tp + j + 2;
                end else begin
                    t_next = tp + 3;
                end
                return;
            end
            burst("erase", col, r, 0, tp + DLY + 1,
                  (st == trig && phase == 2 && m == 0) ? k : 0, plen, te);
            if (st == trig && phase == 2 && m == 1) begin
                step();
                press(plen);
            end
            first = te + 2;
        end
        check_eq("row_never_latched", 0, 1);
        finish_now();
    endtask

    task automatic check_end(input int exp_state, input int exp_win, input int exp_over,
                             input int exp_row);
        int n;
        n = 0;
        repeat (10) begin
            step();
            if (pix.writeEn === 1'b1) n++;
        end
        check_eq("end_quiet", n, 0);
        check_eq("end_state", int'(state_dbg), exp_state);
        check_eq("end_win", int'(win), exp_win);
        check_eq("end_game_over", int'(game_over), exp_over);
        check_eq("end_row_idx", int'(row_idx), exp_row);
        press(2);
        repeat (5) begin
            step();
            if (pix.writeEn === 1'b1) n++;
        end
        check_eq("end_stop_ignored", int'(state_dbg) * 100 + n, exp_state * 100);
        start = 1'b1;
        repeat (3) step();
        check_eq("clear_state", int'(state_dbg), 1);
        check_eq("clear_flags", int'({win, game_over}), 0);
        check_eq("clear_row", int'(row_idx), 0);
        start = 1'b0;
    endtask

    // mode 0: every row aligned, 1: scripted miss on row 1, 2: random
    task automatic play_game(input int mode);
        int prev, t_next, phase, s, k, j, m, plen, col, lo;
        bit want_al;
        int cands[$];
        prev = 0;
        t_next = -1;
        for (int r = 0; r < NR; r++) begin
            phase = $urandom_range(0, 2);
            k = (phase == 0) ? $urandom_range(4, 16) : $urandom_range(1, 16);
            j = $urandom_range(1, DLY);
            m = (phase == 2 && k == 16) ? $urandom_range(0, 1) : 0;
            plen = $urandom_range(1, 3);
            want_al = (mode == 0) || (mode == 2 && $urandom_range(0, 4) != 0);
            lo = (phase == 2) ? 1 : 0;
            cands.delete();
            for (int c = lo; c < 8; c++)
                if (r == 0 || ((tri_col(c) == prev) == want_al)) cands.push_back(c);
            s = cands[$urandom_range(0, cands.size() - 1)];
            if (mode == 0 && r < 2) begin
                s = (r == 0) ? 2 : 4;
            end
            if (mode == 1) begin
                if (r == 0) begin
                    s = 2; phase = 1; j = DLY;
                end else begin
                    s = 3; phase = 0; k = 16; plen = 3;
                end
            end
            play_row(r, s, phase, k, j, m, plen, t_next, t_next);
            col = tri_col(s);
            if (r != 0 && col != prev) begin
                check_end(8, 0, 1, r);
                return;
            end
            if (r == NR - 1) begin
                check_end(7, 1, 0, NR - 1);
                return;
            end
            prev = col;
        end
    endtask

    initial begin
        int n, tp, wx, wy, wc, wt;
        resetn = 1'b0;
        repeat (3) step();
        check_eq("rst_x", int'(pix.x), 0);
        check_eq("rst_y", int'(pix.y), 0);
        check_eq("rst_colour", int'(pix.colour), 0);
        check_eq("rst_writeEn", int'(pix.writeEn), 0);
        check_eq("rst_row_idx", int'(row_idx), 0);
        check_eq("rst_win", int'(win), 0);
        check_eq("rst_game_over", int'(game_over), 0);
        check_eq("rst_state", int'(state_dbg), 0);
        resetn = 1'b1;
        repeat (2) step();
        check_eq("idle_state", int'(state_dbg), 0);
        start = 1'b1;
        n = 0;
        repeat (6) begin
            step();
            if (pix.writeEn === 1'b1) n++;
        end
        check_eq("no_write_while_start", n, 0);
        check_eq("start_held_state", int'(state_dbg), 1);
        start = 1'b0;

        play_game(0);
        play_game(1);
        for (int g = 0; g < 4; g++) play_game(2);

        burst("plot", 0, 0, BLK_C, -1, 0, 1, tp);
        for (int i = 0; i < 5; i++) next_write(wx, wy, wc, wt);
        check_eq("mid_erase_colour", wc, 0);
        resetn = 1'b0;
        #1;
        check_eq("async_rst_writeEn", int'(pix.writeEn), 0);
        check_eq("async_rst_state", int'(state_dbg), 0);
        repeat (2) step();
        resetn = 1'b1;
        finish_now();
    end

endmodule
